// File: rtl/sim_net_buffer.sv
// Buffering stage between the NIC stream ports and the host network endpoint.
// TX is a plain FIFO; RX is either lossless or drops whole packets on overflow.
module sim_net_buffer #(
    parameter int DATA_WIDTH   = 64,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16,
    parameter int RX_DROP_MODE = 0
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  net_out_valid,
    output logic                  net_out_ready,
    input  logic [DATA_WIDTH-1:0] net_out_bits_data,
    input  logic [KEEP_WIDTH-1:0] net_out_bits_keep,
    input  logic                  net_out_bits_last,

    output logic                  host_tx_valid,
    input  logic                  host_tx_ready,
    output logic [DATA_WIDTH-1:0] host_tx_data,
    output logic [KEEP_WIDTH-1:0] host_tx_keep,
    output logic                  host_tx_last,

    input  logic                  host_rx_valid,
    output logic                  host_rx_ready,
    input  logic [DATA_WIDTH-1:0] host_rx_data,
    input  logic [KEEP_WIDTH-1:0] host_rx_keep,
    input  logic                  host_rx_last,

    output logic                  net_in_valid,
    input  logic                  net_in_ready,
    output logic [DATA_WIDTH-1:0] net_in_bits_data,
    output logic [KEEP_WIDTH-1:0] net_in_bits_keep,
    output logic                  net_in_bits_last,

    input  logic                  host_cfg_valid,
    input  logic [47:0]           host_nic_mac_addr,
    input  logic [47:0]           host_switch_mac_addr,
    input  logic [31:0]           host_nic_ip_addr,
    output logic [47:0]           net_nic_mac_addr,
    output logic [47:0]           net_switch_mac_addr,
    output logic [31:0]           net_nic_ip_addr,
    output logic                  net_cfg_locked,
    output logic [31:0]           rx_drop_count
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_OCC = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_OCC = (RX_AW + 1)'(RX_DEPTH);

    typedef enum logic {
        RX_PASS,
        RX_DROP
    } rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_WIDTH-1:0] tx_data_mem [TX_DEPTH];
    logic [KEEP_WIDTH-1:0] tx_keep_mem [TX_DEPTH];
    logic                  tx_last_mem [TX_DEPTH];
    logic [TX_AW:0]        tx_wr_ptr;
    logic [TX_AW:0]        tx_rd_ptr;
    logic [TX_AW:0]        tx_count;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_push;
    logic                  tx_pop;

    assign tx_count = tx_wr_ptr - tx_rd_ptr;
    assign tx_full  = (tx_count == TX_FULL_OCC);
    assign tx_empty = (tx_count == '0);

    // Ready is not early: a full FIFO stalls even when a pop happens this cycle.
    assign net_out_ready = reset && !tx_full;
    assign host_tx_valid = reset && !tx_empty;
    assign tx_push       = net_out_valid && net_out_ready;
    assign tx_pop        = host_tx_valid && host_tx_ready;

    assign host_tx_data = tx_data_mem[tx_rd_ptr[TX_AW-1:0]];
    assign host_tx_keep = tx_keep_mem[tx_rd_ptr[TX_AW-1:0]];
    assign host_tx_last = tx_last_mem[tx_rd_ptr[TX_AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (tx_push) begin
            tx_data_mem[tx_wr_ptr[TX_AW-1:0]] <= net_out_bits_data;
            tx_keep_mem[tx_wr_ptr[TX_AW-1:0]] <= net_out_bits_keep;
            tx_last_mem[tx_wr_ptr[TX_AW-1:0]] <= net_out_bits_last;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_WIDTH-1:0] rx_data_mem [RX_DEPTH];
    logic [KEEP_WIDTH-1:0] rx_keep_mem [RX_DEPTH];
    logic                  rx_last_mem [RX_DEPTH];
    logic [RX_AW:0]        rx_spec_ptr;
    logic [RX_AW:0]        rx_commit_ptr;
    logic [RX_AW:0]        rx_rd_ptr;
    logic [RX_AW:0]        rx_spec_inc;
    logic [RX_AW:0]        rx_spec_occ;
    logic [RX_AW:0]        rx_commit_occ;
    logic                  rx_full;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_wr_en;
    logic                  rx_commit;
    logic                  rx_rewind;
    logic                  rx_drop_inc;
    rx_state_t             rx_state;
    rx_state_t             rx_state_next;

    assign rx_spec_inc   = rx_spec_ptr + 1'b1;
    assign rx_spec_occ   = rx_spec_ptr - rx_rd_ptr;
    assign rx_commit_occ = rx_commit_ptr - rx_rd_ptr;
    assign rx_full       = (rx_spec_occ == RX_FULL_OCC);

    assign host_rx_ready = reset && ((RX_DROP_MODE != 0) || !rx_full);
    assign net_in_valid  = reset && (rx_commit_occ != '0);
    assign rx_push       = host_rx_valid && host_rx_ready;
    assign rx_pop        = net_in_valid && net_in_ready;

    assign net_in_bits_data = rx_data_mem[rx_rd_ptr[RX_AW-1:0]];
    assign net_in_bits_keep = rx_keep_mem[rx_rd_ptr[RX_AW-1:0]];
    assign net_in_bits_last = rx_last_mem[rx_rd_ptr[RX_AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state <= RX_PASS;
        end else begin
            rx_state <= rx_state_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            RX_PASS: begin
                if ((RX_DROP_MODE != 0) && rx_push && rx_full && !host_rx_last)
                    rx_state_next = RX_DROP;
            end
            RX_DROP: begin
                if (rx_push && host_rx_last)
                    rx_state_next = RX_PASS;
            end
            default: rx_state_next = RX_PASS;
        endcase
    end

    // Lossless mode commits every beat; drop mode commits only on a packet's last beat.
    always_comb begin
        rx_wr_en    = 1'b0;
        rx_commit   = 1'b0;
        rx_rewind   = 1'b0;
        rx_drop_inc = 1'b0;
        if (rx_push) begin
            if (RX_DROP_MODE == 0) begin
                rx_wr_en  = 1'b1;
                rx_commit = 1'b1;
            end else begin
                case (rx_state)
                    RX_PASS: begin
                        if (!rx_full) begin
                            rx_wr_en  = 1'b1;
                            rx_commit = host_rx_last;
                        end else begin
                            rx_rewind   = 1'b1;
                            rx_drop_inc = host_rx_last;
                        end
                    end
                    RX_DROP: begin
                        rx_drop_inc = host_rx_last;
                    end
                    default: begin
                        rx_wr_en = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_spec_ptr   <= '0;
            rx_commit_ptr <= '0;
            rx_rd_ptr     <= '0;
        end else begin
            if (rx_wr_en)
                rx_spec_ptr <= rx_spec_inc;
            else if (rx_rewind)
                rx_spec_ptr <= rx_commit_ptr;
            if (rx_commit) rx_commit_ptr <= rx_spec_inc;
            if (rx_pop)    rx_rd_ptr     <= rx_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rx_wr_en) begin
            rx_data_mem[rx_spec_ptr[RX_AW-1:0]] <= host_rx_data;
            rx_keep_mem[rx_spec_ptr[RX_AW-1:0]] <= host_rx_keep;
            rx_last_mem[rx_spec_ptr[RX_AW-1:0]] <= host_rx_last;
        end
    end

    logic [31:0] drop_count_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            drop_count_q <= '0;
        end else if (rx_drop_inc && (drop_count_q != 32'hFFFF_FFFF)) begin
            drop_count_q <= drop_count_q + 32'd1;
        end
    end

    assign rx_drop_count = reset ? drop_count_q : 32'd0;

    // ---------------- one-shot configuration capture ----------------
    logic [47:0] nic_mac_q;
    logic [47:0] switch_mac_q;
    logic [31:0] nic_ip_q;
    logic        locked_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            nic_mac_q    <= '0;
            switch_mac_q <= '0;
            nic_ip_q     <= '0;
            locked_q     <= 1'b0;
        end else if (!locked_q && host_cfg_valid) begin
            nic_mac_q    <= host_nic_mac_addr;
            switch_mac_q <= host_switch_mac_addr;
            nic_ip_q     <= host_nic_ip_addr;
            locked_q     <= 1'b1;
        end
    end

    assign net_nic_mac_addr    = reset ? nic_mac_q    : 48'd0;
    assign net_switch_mac_addr = reset ? switch_mac_q : 48'd0;
    assign net_nic_ip_addr     = reset ? nic_ip_q     : 32'd0;
    assign net_cfg_locked      = reset && locked_q;

endmodule

// File: tb/tb_sim_net_buffer.sv
// Directed bench for sim_net_buffer: one lossless instance and one drop-mode instance share stimulus.
module tb_sim_net_buffer;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic        in_valid;
        logic [63:0] in_data;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [63:0] exp_out_data;
    } tx_vec_t;

    typedef struct {
        beat_t in;
        beat_t exp;
    } rx_vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        net_out_valid;
    logic [63:0] net_out_bits_data;
    logic [7:0]  net_out_bits_keep;
    logic        net_out_bits_last;
    logic        host_tx_ready;
    logic        host_rx_valid;
    logic [63:0] host_rx_data;
    logic [7:0]  host_rx_keep;
    logic        host_rx_last;
    logic        net_in_ready;
    logic        host_cfg_valid;
    logic [47:0] host_nic_mac_addr;
    logic [47:0] host_switch_mac_addr;
    logic [31:0] host_nic_ip_addr;

    logic        net_out_ready_m0, host_tx_valid_m0, host_tx_last_m0, host_rx_ready_m0;
    logic        net_in_valid_m0, net_in_last_m0, cfg_locked_m0;
    logic [63:0] host_tx_data_m0, net_in_data_m0;
    logic [7:0]  host_tx_keep_m0, net_in_keep_m0;
    logic [47:0] nic_mac_m0, switch_mac_m0;
    logic [31:0] nic_ip_m0, drop_count_m0;

    logic        net_out_ready_m1, host_tx_valid_m1, host_tx_last_m1, host_rx_ready_m1;
    logic        net_in_valid_m1, net_in_last_m1, cfg_locked_m1;
    logic [63:0] host_tx_data_m1, net_in_data_m1;
    logic [7:0]  host_tx_keep_m1, net_in_keep_m1;
    logic [47:0] nic_mac_m1, switch_mac_m1;
    logic [31:0] nic_ip_m1, drop_count_m1;

    int total = 0;
    int bad   = 0;

    beat_t   send_q[$];
    beat_t   exp_q[$];
    tx_vec_t tx_vec[11];
    rx_vec_t rx_vec[6];

    always #5 clock = ~clock;

    sim_net_buffer #(.DATA_WIDTH(64), .TX_DEPTH(4), .RX_DEPTH(4), .RX_DROP_MODE(0)) dut0 (
        .clock(clock), .reset(reset),
        .net_out_valid(net_out_valid), .net_out_ready(net_out_ready_m0),
        .net_out_bits_data(net_out_bits_data), .net_out_bits_keep(net_out_bits_keep),
        .net_out_bits_last(net_out_bits_last),
        .host_tx_valid(host_tx_valid_m0), .host_tx_ready(host_tx_ready),
        .host_tx_data(host_tx_data_m0), .host_tx_keep(host_tx_keep_m0), .host_tx_last(host_tx_last_m0),
        .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready_m0),
        .host_rx_data(host_rx_data), .host_rx_keep(host_rx_keep), .host_rx_last(host_rx_last),
        .net_in_valid(net_in_valid_m0), .net_in_ready(net_in_ready),
        .net_in_bits_data(net_in_data_m0), .net_in_bits_keep(net_in_keep_m0),
        .net_in_bits_last(net_in_last_m0),
        .host_cfg_valid(host_cfg_valid), .host_nic_mac_addr(host_nic_mac_addr),
        .host_switch_mac_addr(host_switch_mac_addr), .host_nic_ip_addr(host_nic_ip_addr),
        .net_nic_mac_addr(nic_mac_m0), .net_switch_mac_addr(switch_mac_m0),
        .net_nic_ip_addr(nic_ip_m0), .net_cfg_locked(cfg_locked_m0), .rx_drop_count(drop_count_m0)
    );

    sim_net_buffer #(.DATA_WIDTH(64), .TX_DEPTH(4), .RX_DEPTH(4), .RX_DROP_MODE(1)) dut1 (
        .clock(clock), .reset(reset),
        .net_out_valid(net_out_valid), .net_out_ready(net_out_ready_m1),
        .net_out_bits_data(net_out_bits_data), .net_out_bits_keep(net_out_bits_keep),
        .net_out_bits_last(net_out_bits_last),
        .host_tx_valid(host_tx_valid_m1), .host_tx_ready(host_tx_ready),
        .host_tx_data(host_tx_data_m1), .host_tx_keep(host_tx_keep_m1), .host_tx_last(host_tx_last_m1),
        .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready_m1),
        .host_rx_data(host_rx_data), .host_rx_keep(host_rx_keep), .host_rx_last(host_rx_last),
        .net_in_valid(net_in_valid_m1), .net_in_ready(net_in_ready),
        .net_in_bits_data(net_in_data_m1), .net_in_bits_keep(net_in_keep_m1),
        .net_in_bits_last(net_in_last_m1),
        .host_cfg_valid(host_cfg_valid), .host_nic_mac_addr(host_nic_mac_addr),
        .host_switch_mac_addr(host_switch_mac_addr), .host_nic_ip_addr(host_nic_ip_addr),
        .net_nic_mac_addr(nic_mac_m1), .net_switch_mac_addr(switch_mac_m1),
        .net_nic_ip_addr(nic_ip_m1), .net_cfg_locked(cfg_locked_m1), .rx_drop_count(drop_count_m1)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input tx_vec_t v, input int row);
        net_out_valid     = v.in_valid;
        net_out_bits_data = v.in_data;
        net_out_bits_keep = 8'hFF;
        net_out_bits_last = 1'b0;
        host_tx_ready     = v.out_ready;
        @(negedge clock);
        checkOutput($sformatf("tx_in_ready[%0d]", row), 64'(net_out_ready_m0), 64'(v.exp_in_ready));
        checkOutput($sformatf("tx_out_valid[%0d]", row), 64'(host_tx_valid_m0), 64'(v.exp_out_valid));
        if (v.exp_out_valid)
            checkOutput($sformatf("tx_out_data[%0d]", row), host_tx_data_m0, v.exp_out_data);
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        net_out_valid = 1'b0; net_out_bits_data = '0; net_out_bits_keep = '0; net_out_bits_last = 1'b0;
        host_tx_ready = 1'b0; host_rx_valid = 1'b0; host_rx_data = '0; host_rx_keep = '0;
        host_rx_last = 1'b0; net_in_ready = 1'b0; host_cfg_valid = 1'b0;
        host_nic_mac_addr = '0; host_switch_mac_addr = '0; host_nic_ip_addr = '0;
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("rst_held_out_ready", 64'(net_out_ready_m0), 64'd0);
        checkOutput("rst_held_rx_ready", 64'(host_rx_ready_m1), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("idle_out_ready", 64'(net_out_ready_m0), 64'd1);
        checkOutput("idle_rx_ready_m0", 64'(host_rx_ready_m0), 64'd1);
        checkOutput("idle_rx_ready_m1", 64'(host_rx_ready_m1), 64'd1);
        checkOutput("idle_tx_valid", 64'(host_tx_valid_m0), 64'd0);
        checkOutput("idle_in_valid_m0", 64'(net_in_valid_m0), 64'd0);
        checkOutput("idle_in_valid_m1", 64'(net_in_valid_m1), 64'd0);
        checkOutput("idle_locked", 64'(cfg_locked_m0), 64'd0);
        checkOutput("idle_drop_count", 64'(drop_count_m1), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic sendBeat(input beat_t b, input bit sel);
        host_rx_valid = 1'b1;
        host_rx_data  = b.data;
        host_rx_keep  = b.keep;
        host_rx_last  = b.last;
        @(negedge clock);
        checkOutput("rx_ready_on_send", 64'(sel ? host_rx_ready_m1 : host_rx_ready_m0), 64'd1);
        @(posedge clock);
        #1;
        host_rx_valid = 1'b0;
    endtask

    // Streams send_q into the chosen instance with the NIC always ready and matches every delivered beat against exp_q.
    task automatic streamRx(input bit sel, input int budget);
        int    cyc = 0;
        logic  accepted;
        beat_t e;
        while ((send_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            host_rx_valid = (send_q.size() > 0);
            if (send_q.size() > 0) begin
                host_rx_data = send_q[0].data;
                host_rx_keep = send_q[0].keep;
                host_rx_last = send_q[0].last;
            end
            net_in_ready = 1'b1;
            @(negedge clock);
            if (sel ? net_in_valid_m1 : net_in_valid_m0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rx_extra_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rx_data", sel ? net_in_data_m1 : net_in_data_m0, e.data);
                    checkOutput("rx_keep", 64'(sel ? net_in_keep_m1 : net_in_keep_m0), 64'(e.keep));
                    checkOutput("rx_last", 64'(sel ? net_in_last_m1 : net_in_last_m0), 64'(e.last));
                end
            end
            accepted = host_rx_valid && (sel ? host_rx_ready_m1 : host_rx_ready_m0);
            @(posedge clock);
            #1;
            if (accepted) void'(send_q.pop_front());
            cyc++;
        end
        host_rx_valid = 1'b0;
        if (cyc >= budget) begin
            checkOutput("rx_stream_timeout", 64'(cyc), 64'(budget - 1));
            send_q.delete();
            exp_q.delete();
        end
        @(negedge clock);
        checkOutput("rx_drained_valid", 64'(sel ? net_in_valid_m1 : net_in_valid_m0), 64'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        beat_t a0, a1, b0, b1, b2, b3, c0, c1, r0, r1, r2;

        // {in_valid, in_data, out_ready, exp_in_ready, exp_out_valid, exp_out_data}
        tx_vec[0]  = '{1'b1, 64'h11, 1'b0, 1'b1, 1'b0, 64'h00};
        tx_vec[1]  = '{1'b1, 64'h22, 1'b0, 1'b1, 1'b1, 64'h11};
        tx_vec[2]  = '{1'b1, 64'h33, 1'b0, 1'b1, 1'b1, 64'h11};
        tx_vec[3]  = '{1'b1, 64'h44, 1'b0, 1'b1, 1'b1, 64'h11};
        tx_vec[4]  = '{1'b1, 64'h55, 1'b0, 1'b0, 1'b1, 64'h11};
        tx_vec[5]  = '{1'b1, 64'h55, 1'b1, 1'b0, 1'b1, 64'h11};
        tx_vec[6]  = '{1'b1, 64'h55, 1'b1, 1'b1, 1'b1, 64'h22};
        tx_vec[7]  = '{1'b0, 64'h00, 1'b1, 1'b1, 1'b1, 64'h33};
        tx_vec[8]  = '{1'b0, 64'h00, 1'b1, 1'b1, 1'b1, 64'h44};
        tx_vec[9]  = '{1'b0, 64'h00, 1'b1, 1'b1, 1'b1, 64'h55};
        tx_vec[10] = '{1'b0, 64'h00, 1'b1, 1'b1, 1'b0, 64'h00};

        rx_vec[0] = '{'{64'hA1, 8'hFF, 1'b0}, '{64'hA1, 8'hFF, 1'b0}};
        rx_vec[1] = '{'{64'hA2, 8'h0F, 1'b0}, '{64'hA2, 8'h0F, 1'b0}};
        rx_vec[2] = '{'{64'hA3, 8'h01, 1'b1}, '{64'hA3, 8'h01, 1'b1}};
        rx_vec[3] = '{'{64'hA4, 8'hFF, 1'b0}, '{64'hA4, 8'hFF, 1'b0}};
        rx_vec[4] = '{'{64'hA5, 8'hF0, 1'b0}, '{64'hA5, 8'hF0, 1'b0}};
        rx_vec[5] = '{'{64'hA6, 8'h03, 1'b1}, '{64'hA6, 8'h03, 1'b1}};

        // Reset release and TX fill / backpressure
        doReset();
        for (int i = 0; i < 11; i++) applyStimulus(tx_vec[i], i);
        net_out_valid = 1'b0;
        host_tx_ready = 1'b0;

        // RX lossless with the NIC stalled until the FIFO fills
        doReset();
        net_in_ready = 1'b0;
        for (int i = 0; i < 4; i++) sendBeat(rx_vec[i].in, 1'b0);
        host_rx_valid = 1'b1;
        host_rx_data  = rx_vec[4].in.data;
        host_rx_keep  = rx_vec[4].in.keep;
        host_rx_last  = rx_vec[4].in.last;
        @(negedge clock);
        checkOutput("lossless_full_ready", 64'(host_rx_ready_m0), 64'd0);
        checkOutput("lossless_full_in_valid", 64'(net_in_valid_m0), 64'd1);
        @(posedge clock);
        #1;
        send_q.push_back(rx_vec[4].in);
        send_q.push_back(rx_vec[5].in);
        for (int i = 0; i < 6; i++) exp_q.push_back(rx_vec[i].exp);
        streamRx(1'b0, 40);
        checkOutput("lossless_drop_count", 64'(drop_count_m0), 64'd0);

        // RX drop: committed A stays, oversize B is dropped, C follows intact
        a0 = '{64'hB001, 8'hFF, 1'b0}; a1 = '{64'hB002, 8'h3F, 1'b1};
        b0 = '{64'hC001, 8'hFF, 1'b0}; b1 = '{64'hC002, 8'hFF, 1'b0};
        b2 = '{64'hC003, 8'hFF, 1'b0}; b3 = '{64'hC004, 8'h0F, 1'b1};
        c0 = '{64'hD001, 8'hFF, 1'b0}; c1 = '{64'hD002, 8'h07, 1'b1};
        doReset();
        net_in_ready = 1'b0;
        sendBeat(a0, 1'b1); sendBeat(a1, 1'b1);
        sendBeat(b0, 1'b1); sendBeat(b1, 1'b1); sendBeat(b2, 1'b1); sendBeat(b3, 1'b1);
        @(negedge clock);
        checkOutput("drop_count_after_b", 64'(drop_count_m1), 64'd1);
        checkOutput("drop_a_visible", 64'(net_in_valid_m1), 64'd1);
        @(posedge clock);
        #1;
        exp_q.push_back(a0); exp_q.push_back(a1);
        streamRx(1'b1, 20);
        send_q.push_back(c0); send_q.push_back(c1);
        exp_q.push_back(c0); exp_q.push_back(c1);
        streamRx(1'b1, 20);
        checkOutput("drop_count_after_c", 64'(drop_count_m1), 64'd1);

        // Config capture is one-shot until reset
        doReset();
        checkOutput("cfg_mac_before_lock", 64'(nic_mac_m0), 64'd0);
        host_cfg_valid       = 1'b1;
        host_nic_mac_addr    = 48'h0A0B0C0D0E0F;
        host_switch_mac_addr = 48'h112233445566;
        host_nic_ip_addr     = 32'h0A000001;
        @(posedge clock);
        #1;
        host_cfg_valid = 1'b0;
        @(negedge clock);
        checkOutput("cfg_locked", 64'(cfg_locked_m0), 64'd1);
        checkOutput("cfg_nic_mac", 64'(nic_mac_m0), 64'h0A0B0C0D0E0F);
        checkOutput("cfg_switch_mac", 64'(switch_mac_m0), 64'h112233445566);
        checkOutput("cfg_nic_ip", 64'(nic_ip_m0), 64'h0A000001);
        @(posedge clock);
        #1;
        host_cfg_valid       = 1'b1;
        host_nic_mac_addr    = 48'hFFEEDDCCBBAA;
        host_switch_mac_addr = 48'h998877665544;
        host_nic_ip_addr     = 32'hC0A80101;
        @(posedge clock);
        #1;
        host_cfg_valid = 1'b0;
        @(negedge clock);
        checkOutput("cfg_relock_nic_mac", 64'(nic_mac_m0), 64'h0A0B0C0D0E0F);
        checkOutput("cfg_relock_switch_mac", 64'(switch_mac_m0), 64'h112233445566);
        checkOutput("cfg_relock_nic_ip", 64'(nic_ip_m0), 64'h0A000001);
        @(posedge clock);
        #1;

        // Reset in the middle of a drop-mode packet
        r0 = '{64'hE001, 8'hFF, 1'b0}; r1 = '{64'hE002, 8'hFF, 1'b0}; r2 = '{64'hE003, 8'h01, 1'b1};
        doReset();
        net_in_ready = 1'b0;
        sendBeat(r0, 1'b1); sendBeat(r1, 1'b1);
        doReset();
        send_q.push_back(r0); send_q.push_back(r1); send_q.push_back(r2);
        exp_q.push_back(r0); exp_q.push_back(r1); exp_q.push_back(r2);
        streamRx(1'b1, 20);
        checkOutput("midreset_drop_count", 64'(drop_count_m1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
